// File: rtl/gs_pkg.sv
// Shared constants and helpers for the 5-tap binomial (1,4,6,4,1) separable filter.
//
// Contents:
//   ROW_SAMPLES / IMG_W - default samples per input line and outputs per line
//   TAP_W0..TAP_W4      - binomial tap weights, oldest sample first
//   RND / SHIFT         - rounding constant and normalising shift (weights sum to 16)
//   pass_e              - which pass of the separable filter a line belongs to
//   round_shift()       - rounded normalisation of a 12-bit weighted sum
package gs_pkg;

  localparam int unsigned ROW_SAMPLES = 260;
  localparam int unsigned IMG_W       = 256;

  // Number of samples in the filter window.
  localparam int unsigned WinDepth = 5;

  localparam logic [11:0] TAP_W0 = 12'd1;
  localparam logic [11:0] TAP_W1 = 12'd4;
  localparam logic [11:0] TAP_W2 = 12'd6;
  localparam logic [11:0] TAP_W3 = 12'd4;
  localparam logic [11:0] TAP_W4 = 12'd1;

  localparam logic [11:0] RND   = 12'd8;
  localparam int unsigned SHIFT = 4;

  typedef enum logic [0:0] {
    PassHoriz = 1'b0,
    PassVert  = 1'b1
  } pass_e;

  // Max sum is 16*255 = 4080, so sum+8 still fits in 12 bits and the result fits in 8.
  function automatic logic [7:0] round_shift(input logic [11:0] sum);
    logic [11:0] r;
    r = (sum + RND) >> SHIFT;
    return r[7:0];
  endfunction

endpackage

// File: rtl/gs_tap5.sv
// Five-sample sliding window and weighted sum for the binomial filter.
//
// The window is the four most recently accepted samples (p0 oldest .. p3) held in
// registers plus the sample being presented this cycle (p4 = din). The sum output is
// therefore the weighted sum of the window that includes din, so the caller can
// register it in the same cycle the sample is accepted.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears the window
//   shift_en - accept din into the window at the next rising edge
//   din      - incoming 8-bit sample (window position p4)
//   sum      - 12-bit p0 + 4*p1 + 6*p2 + 4*p3 + p4, combinational
module gs_tap5 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [11:0] sum
);
  import gs_pkg::*;

  logic [7:0] p0_q, p0_d;
  logic [7:0] p1_q, p1_d;
  logic [7:0] p2_q, p2_d;
  logic [7:0] p3_q, p3_d;

  always_comb begin
    p0_d = p0_q;
    p1_d = p1_q;
    p2_d = p2_q;
    p3_d = p3_q;
    if (shift_en) begin
      p0_d = p1_q;
      p1_d = p2_q;
      p2_d = p3_q;
      p3_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_q <= '0;
      p1_q <= '0;
      p2_q <= '0;
      p3_q <= '0;
    end else begin
      p0_q <= p0_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      p3_q <= p3_d;
    end
  end

  always_comb begin
    sum = TAP_W0 * {4'd0, p0_q}
        + TAP_W1 * {4'd0, p1_q}
        + TAP_W2 * {4'd0, p2_q}
        + TAP_W3 * {4'd0, p3_q}
        + TAP_W4 * {4'd0, din};
  end

endmodule

// File: rtl/gs_dt_filt.sv
// Separable 5-tap binomial filter with a transposing intermediate store.
//
// Pass 0 filters each line read from ram0 horizontally and writes the results to ram1
// at {line, idx}. Pass 1 filters ram1 lines (i.e. image columns) and emits the final
// pixels at {idx, line}, which undoes the transpose so out_addr is row-major.
//
// Ports:
//   clk, rst_n     - clock (rising edge) and asynchronous active-low reset
//   start          - one-cycle frame start; clears counters and in-flight outputs
//   pix_valid      - pix_data carries a sample this cycle
//   pix_pass       - pass of the current line, sampled on the first sample of a line
//   pix_data       - 8-bit sample
//   mid_wr_*       - intermediate RAM write port (pass 0 results)
//   out_*          - final pixel strobe, row-major address and data (pass 1 results)
//   line_done      - pulses with the last output of every line
//   frame_done     - pulses with the last output of pass 1
module gs_dt_filt #(
  parameter int unsigned ROW_SAMPLES = gs_pkg::ROW_SAMPLES,
  parameter int unsigned IMG_W       = gs_pkg::IMG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pix_valid,
  input  logic        pix_pass,
  input  logic [7:0]  pix_data,
  output logic        mid_wr_valid,
  output logic [15:0] mid_wr_addr,
  output logic [7:0]  mid_wr_data,
  output logic        out_valid,
  output logic [15:0] out_addr,
  output logic [7:0]  out_data,
  output logic        line_done,
  output logic        frame_done
);
  import gs_pkg::*;

  localparam logic [8:0] ColLast     = 9'(ROW_SAMPLES - 1);
  localparam logic [8:0] ColFirstOut = 9'(WinDepth - 1);
  localparam logic [7:0] IdxLast     = 8'(IMG_W - 1);
  localparam logic [7:0] LineLast    = 8'hFF;

  // A sample coincident with start belongs to the old frame and is dropped.
  logic accept;
  assign accept = pix_valid & ~start;

  // Line counters and latched pass.
  logic [8:0] col_q, col_d;
  logic [7:0] line_q, line_d;
  pass_e      pass_q, pass_d;
  pass_e      cur_pass;

  // Stage 1: weighted sum and its coordinates.
  logic        s1_valid_q, s1_valid_d;
  logic [11:0] s1_sum_q, s1_sum_d;
  logic [7:0]  s1_idx_q, s1_idx_d;
  logic [7:0]  s1_line_q, s1_line_d;
  pass_e       s1_pass_q, s1_pass_d;

  // Stage 2: registered outputs.
  logic        mid_wr_valid_q, mid_wr_valid_d;
  logic [15:0] mid_wr_addr_q, mid_wr_addr_d;
  logic [7:0]  mid_wr_data_q, mid_wr_data_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_addr_q, out_addr_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        line_done_q, line_done_d;
  logic        frame_done_q, frame_done_d;

  logic [11:0] tap_sum;
  logic [7:0]  res;

  gs_tap5 u_tap5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .din      (pix_data),
    .sum      (tap_sum)
  );

  // Pass is only taken from the first sample of a line; later toggles are ignored.
  always_comb begin
    cur_pass = pass_q;
    if (col_q == '0) begin
      cur_pass = pass_e'(pix_pass);
    end
  end

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    pass_d = pass_q;
    if (start) begin
      col_d  = '0;
      line_d = '0;
    end else if (pix_valid) begin
      pass_d = cur_pass;
      if (col_q == ColLast) begin
        col_d  = '0;
        line_d = line_q + 8'd1;  // wraps 255 -> 0 between passes
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  // The first four samples of a line only prime the window.
  always_comb begin
    s1_valid_d = accept && (col_q >= ColFirstOut);
    s1_sum_d   = s1_sum_q;
    s1_idx_d   = s1_idx_q;
    s1_line_d  = s1_line_q;
    s1_pass_d  = s1_pass_q;
    if (accept) begin
      s1_sum_d  = tap_sum;
      s1_idx_d  = 8'(col_q - ColFirstOut);
      s1_line_d = line_q;
      s1_pass_d = cur_pass;
    end
  end

  assign res = round_shift(s1_sum_q);

  // start drops the result currently in stage 1 so nothing from the old frame escapes.
  always_comb begin
    mid_wr_valid_d = 1'b0;
    mid_wr_addr_d  = '0;
    mid_wr_data_d  = '0;
    out_valid_d    = 1'b0;
    out_addr_d     = '0;
    out_data_d     = '0;
    line_done_d    = 1'b0;
    frame_done_d   = 1'b0;
    if (s1_valid_q && !start) begin
      line_done_d = (s1_idx_q == IdxLast);
      if (s1_pass_q == PassHoriz) begin
        mid_wr_valid_d = 1'b1;
        mid_wr_addr_d  = {s1_line_q, s1_idx_q};
        mid_wr_data_d  = res;
      end else begin
        out_valid_d  = 1'b1;
        out_addr_d   = {s1_idx_q, s1_line_q};
        out_data_d   = res;
        frame_done_d = (s1_idx_q == IdxLast) && (s1_line_q == LineLast);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q          <= '0;
      line_q         <= '0;
      pass_q         <= PassHoriz;
      s1_valid_q     <= 1'b0;
      s1_sum_q       <= '0;
      s1_idx_q       <= '0;
      s1_line_q      <= '0;
      s1_pass_q      <= PassHoriz;
      mid_wr_valid_q <= 1'b0;
      mid_wr_addr_q  <= '0;
      mid_wr_data_q  <= '0;
      out_valid_q    <= 1'b0;
      out_addr_q     <= '0;
      out_data_q     <= '0;
      line_done_q    <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      line_q         <= line_d;
      pass_q         <= pass_d;
      s1_valid_q     <= s1_valid_d;
      s1_sum_q       <= s1_sum_d;
      s1_idx_q       <= s1_idx_d;
      s1_line_q      <= s1_line_d;
      s1_pass_q      <= s1_pass_d;
      mid_wr_valid_q <= mid_wr_valid_d;
      mid_wr_addr_q  <= mid_wr_addr_d;
      mid_wr_data_q  <= mid_wr_data_d;
      out_valid_q    <= out_valid_d;
      out_addr_q     <= out_addr_d;
      out_data_q     <= out_data_d;
      line_done_q    <= line_done_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign mid_wr_valid = mid_wr_valid_q;
  assign mid_wr_addr  = mid_wr_addr_q;
  assign mid_wr_data  = mid_wr_data_q;
  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_data     = out_data_q;
  assign line_done    = line_done_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_gs_dt_filt.sv
// Randomised bench for gs_dt_filt: each line's expected outputs are computed from the
// whole line of samples with plain arithmetic and queued with the cycle they must appear.
module tb_gs_dt_filt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_pass = 1'b0;
  logic [7:0]  pix_data = 8'd0;
  logic        mid_wr_valid;
  logic [15:0] mid_wr_addr;
  logic [7:0]  mid_wr_data;
  logic        out_valid;
  logic [15:0] out_addr;
  logic [7:0]  out_data;
  logic        line_done;
  logic        frame_done;

  always #5 clk = ~clk;

  gs_dt_filt dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .pix_valid    (pix_valid),
    .pix_pass     (pix_pass),
    .pix_data     (pix_data),
    .mid_wr_valid (mid_wr_valid),
    .mid_wr_addr  (mid_wr_addr),
    .mid_wr_data  (mid_wr_data),
    .out_valid    (out_valid),
    .out_addr     (out_addr),
    .out_data     (out_data),
    .line_done    (line_done),
    .frame_done   (frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {4'b0, stamp[23:0], mid_v, out_v, mid_addr, mid_data, out_addr, out_data, ld, fd}
  function automatic logic [79:0] pack(input int stamp, input logic mv, input logic ov,
                                       input logic [15:0] ma, input logic [7:0] md,
                                       input logic [15:0] oa, input logic [7:0] od,
                                       input logic ld, input logic fd);
    logic [23:0] s;
    s = 24'(stamp);
    return {4'b0, s, mv, ov, ma, md, oa, od, ld, fd};
  endfunction

  function automatic logic [79:0] observe(input int stamp);
    return pack(stamp, mid_wr_valid, out_valid, mid_wr_addr, mid_wr_data, out_addr, out_data,
                line_done, frame_done);
  endfunction

  function automatic int stamp_of(input logic [79:0] e);
    return int'(e[75:52]);
  endfunction

  logic [79:0] expq[$];
  int          neg_cnt = 0;
  bit          mon_en = 1'b0;

  // Every cycle: either the next expected strobe is due now, or all outputs must be idle.
  always @(negedge clk) begin
    logic [79:0] e;
    neg_cnt++;
    if (mon_en) begin
      if (expq.size() > 0 && stamp_of(expq[0]) == neg_cnt) begin
        e = expq.pop_front();
        check_eq("strobe", observe(neg_cnt), e);
      end else begin
        check_eq("idle", observe(neg_cnt), pack(neg_cnt, 0, 0, 0, 0, 0, 0, 0, 0));
      end
    end
  end

  logic [7:0] line_buf [260];
  int         m_line = 0;

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 260; i++) line_buf[i] = v;
  endtask

  task automatic fill_impulse(input int pos, input logic [7:0] v);
    for (int i = 0; i < 260; i++) line_buf[i] = (i == pos) ? v : 8'd0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 260; i++) line_buf[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_data  = 8'($urandom_range(0, 255));
    end
  endtask

  // gap_mode: 0 continuous, 1 one idle cycle between samples, 2 random idle bursts.
  task automatic send_line(input logic pass0, input int gap_mode, input int nsamp);
    int          stamp;
    int          sum;
    logic [7:0]  dat;
    logic [7:0]  i8;
    logic [7:0]  l8;
    for (int c = 0; c < nsamp; c++) begin
      if (gap_mode == 1 && c > 0) idle(1);
      else if (gap_mode == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      @(posedge clk);
      #1;
      pix_valid = 1'b1;
      pix_data  = line_buf[c];
      pix_pass  = (c == 0) ? pass0 : 1'($urandom_range(0, 1));
      stamp     = neg_cnt + 3;
      if (c >= 4) begin
        sum = int'(line_buf[c-4]) + 4 * int'(line_buf[c-3]) + 6 * int'(line_buf[c-2])
            + 4 * int'(line_buf[c-1]) + int'(line_buf[c]);
        dat = 8'((sum + 8) / 16);
        i8  = 8'(c - 4);
        l8  = 8'(m_line);
        if (!pass0) expq.push_back(pack(stamp, 1, 0, {l8, i8}, dat, 16'h0, 8'h0,
                                        i8 == 8'hFF, 1'b0));
        else        expq.push_back(pack(stamp, 0, 1, 16'h0, 8'h0, {i8, l8}, dat,
                                        i8 == 8'hFF, (i8 == 8'hFF) && (l8 == 8'hFF)));
      end
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    if (nsamp == 260) m_line = (m_line + 1) % 256;
  endtask

  initial begin
    int c;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", observe(0), 80'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_outputs", observe(0), 80'h0);
    mon_en = 1'b1;

    // Constant line, impulse line, toggled-valid line, vertical constant line.
    fill_const(8'd100);        send_line(1'b0, 0, 260);
    fill_impulse(10, 8'd255);  send_line(1'b0, 0, 260);
    fill_rand();               send_line(1'b0, 1, 260);
    fill_const(8'd200);        send_line(1'b1, 0, 260);
    for (int l = 0; l < 4; l++) begin
      fill_rand();
      send_line(1'($urandom_range(0, 1)), 2, 260);
    end

    // start mid-line together with a sample: in-flight results and that sample are dropped.
    fill_rand();
    send_line(1'b0, 0, 50);
    @(posedge clk);
    #1;
    start     = 1'b1;
    pix_valid = 1'b1;
    pix_data  = 8'($urandom_range(0, 255));
    c = neg_cnt + 1;
    while (expq.size() > 0 && stamp_of(expq[expq.size()-1]) > c) void'(expq.pop_back());
    @(posedge clk);
    #1;
    start     = 1'b0;
    pix_valid = 1'b0;
    m_line    = 0;
    fill_rand();
    send_line(1'b0, 2, 260);

    // Reset at col 100, then start and a fresh line.
    fill_rand();
    send_line(1'b1, 0, 101);
    rst_n = 1'b0;
    expq.delete();
    idle(3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    m_line = 0;
    fill_rand();
    send_line(1'b0, 0, 260);

    // Run up to line 255, finish it as a vertical line, then check the line wrap.
    while (m_line != 255) begin
      fill_rand();
      send_line(1'b0, 0, 260);
    end
    fill_rand();
    send_line(1'b1, 0, 260);
    fill_rand();
    send_line(1'b0, 0, 260);

    idle(6);
    check_eq("drain", 80'(expq.size()), 80'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
